rom_frame_tx: RTL and testbench

Frame sequencer and serializer that sits directly downstream of the 16-entry registered ROM. On a start request it walks the ROM addresses 0..15 and absorbs the ROM's one-cycle read latency. Each returned byte is shifted out MSB-first on a single serial line at a programmable bit rate, with a bit-valid strobe. It produces the complete 16-byte frame: header 0x5A, 14 fill bytes 0x7E, trailer 0x6B.

---
 rtl/rom_frame_tx.sv | 130 +++++++++++++
 tb/tb_rom_frame_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_frame_tx.sv
// Frame sequencer/serializer for a 16-entry registered ROM: walks addresses 0..15,
// absorbs the ROM read latency and shifts each byte out MSB-first at CLKS_PER_BIT clocks/bit.
module rom_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StFetch, StLoad, StShift} state_e;

  localparam logic [7:0] LastCnt = 8'(CLKS_PER_BIT - 1);

  state_e     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [6:0] shift_q, shift_d;  // bits still to send after the one on ser_out
  logic [2:0] bit_q, bit_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ser_q, ser_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    ser_d   = ser_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (abort) begin
      // IDLE already holds reset values, so abort can clear unconditionally
      state_d = StIdle;
      addr_d  = '0;
      shift_d = '0;
      bit_d   = '0;
      cnt_d   = '0;
      ser_d   = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            addr_d  = '0;
            busy_d  = 1'b1;
            state_d = StFetch;
          end
        end
        StFetch: state_d = StLoad;
        StLoad: begin
          shift_d = rom_data[6:0];
          ser_d   = rom_data[7];
          valid_d = 1'b1;
          bit_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
        StShift: begin
          if (cnt_q == LastCnt) begin
            cnt_d = '0;
            if (bit_q != 3'd7) begin
              ser_d   = shift_q[6];
              shift_d = {shift_q[5:0], 1'b0};
              bit_d   = bit_q + 3'd1;
            end else begin
              ser_d   = 1'b0;
              valid_d = 1'b0;
              if (addr_q == 4'hF) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                addr_d  = '0;
                state_d = StIdle;
              end else begin
                addr_d  = addr_q + 4'd1;
                state_d = StFetch;
              end
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr  = addr_q;
  assign ser_out   = ser_q;
  assign ser_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rom_frame_tx.sv
// Bench for rom_frame_tx: two instances (4 and 1 clocks/bit) with registered ROM models,
// checked every cycle against a frame-position model plus literal timing/content checks.
module tb_rom_frame_tx;

  localparam int NA = 4;
  localparam int NB = 1;
  localparam int PA = 2 + 8 * NA;
  localparam int PB = 2 + 8 * NB;
  localparam int FA = 16 * PA;
  localparam int FB = 16 * PB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic [3:0] addr_a, addr_b;
  logic       ser_a, ser_b, val_a, val_b, busy_a, busy_b, done_a, done_b;

  int vectors = 0;
  int miscompares = 0;
  // cycles since the accepting edge; -1 when idle, F on the done cycle
  int c_a = -1;
  int c_b = -1;

  always #5 clk = ~clk;

  rom_frame_tx #(.CLKS_PER_BIT(NA)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .rom_addr(addr_a),
    .rom_data(data_a), .ser_out(ser_a), .ser_valid(val_a), .busy(busy_a), .done(done_a)
  );

  rom_frame_tx #(.CLKS_PER_BIT(NB)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .rom_addr(addr_b),
    .rom_data(data_b), .ser_out(ser_b), .ser_valid(val_b), .busy(busy_b), .done(done_b)
  );

  function automatic logic [7:0] frame_byte(int i);
    if (i == 0) return 8'h5A;
    if (i == 15) return 8'h6B;
    return 8'h7E;
  endfunction

  always @(posedge clk) begin
    data_a <= frame_byte(int'(addr_a));
    data_b <= frame_byte(int'(addr_b));
  end

  function automatic int next_c(int c, int f);
    if (rst) return -1;
    if (c >= 0 && c < f) return abort ? -1 : c + 1;
    return (start && !abort) ? 0 : -1;
  endfunction

  always @(posedge clk) begin
    c_a <= next_c(c_a, FA);
    c_b <= next_c(c_b, FB);
  end

  // {rom_addr, ser_out, ser_valid, busy, done}
  function automatic logic [7:0] expect_outs(int c, int n);
    int p;
    int i;
    int r;
    logic [7:0] byte_v;
    logic b;
    p = 2 + 8 * n;
    if (c < 0) return 8'h00;
    if (c == 16 * p) return 8'h01;
    i = c / p;
    r = c % p;
    if (r < 2) return {4'(i), 4'b0010};
    byte_v = frame_byte(i);
    b = byte_v[7 - (r - 2) / n];
    return {4'(i), b, 3'b110};
  endfunction

  task automatic cmp(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("dut_a outputs", int'({addr_a, ser_a, val_a, busy_a, done_a}), int'(expect_outs(c_a, NA)));
    cmp("dut_b outputs", int'({addr_b, ser_b, val_b, busy_b, done_b}), int'(expect_outs(c_b, NB)));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Pulse start and observe one full frame on both instances.
  task automatic run_frame(string tag);
    int done_at_a;
    int done_at_b;
    int steps;
    int hi_a;
    int hi_b;
    logic [7:0] b0;
    logic [7:0] b15;
    logic [3:0] last;
    done_at_a = -1;
    done_at_b = -1;
    steps = 0;
    hi_a = 0;
    hi_b = 0;
    b0 = '0;
    b15 = '0;
    last = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= FA + 2; c++) begin
      if (c >= 2 && c < 2 + 8 * NA && (c - 2) % NA == 0) b0 = {b0[6:0], ser_a};
      if (c >= 15 * PA + 2 && c < 15 * PA + 2 + 8 * NA && (c - 15 * PA - 2) % NA == 0)
        b15 = {b15[6:0], ser_a};
      if (done_a && done_at_a < 0) done_at_a = c;
      if (done_b && done_at_b < 0) done_at_b = c;
      if (c < FA && val_a) hi_a++;
      if (c < FB && val_b) hi_b++;
      if (addr_a != last) begin
        if (int'(addr_a) == int'(last) + 1) steps++;
        last = addr_a;
      end
      if (c == 10 || c == 11) cmp({tag, " n1 gap low"}, int'(val_b), 0);
      if (c == 9 || c == 12) cmp({tag, " n1 burst high"}, int'(val_b), 1);
      tick();
    end
    cmp({tag, " first byte"}, int'(b0), 'h5A);
    cmp({tag, " last byte"}, int'(b15), 'h6B);
    cmp({tag, " done cycle n4"}, done_at_a, 544);
    cmp({tag, " done cycle n1"}, done_at_b, 160);
    cmp({tag, " addr steps"}, steps, 15);
    cmp({tag, " valid cycles n4"}, hi_a, 512);
    cmp({tag, " valid cycles n1"}, hi_b, 128);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    cmp("reset outputs", int'({addr_a, ser_a, val_a, busy_a, done_a}), 0);

    cnt = 0;
    repeat (100) begin
      tick();
      if (val_a || val_b || busy_a || busy_b) cnt++;
    end
    cmp("idle activity", cnt, 0);

    run_frame("frame1");
    repeat (5) tick();

    // start held high across the whole frame
    start = 1'b1;
    tick();
    cnt = 0;
    for (int c = 0; c < FA + 4; c++) begin
      if (c > 0 && c < FA && done_a) cnt++;
      if (c == FA) cmp("held start done", int'(done_a), 1);
      if (c == FA + 1) cmp("held start busy again", int'(busy_a), 1);
      if (c == FA + 2) cmp("held start gap", int'(val_a), 0);
      if (c == FA + 3) cmp("held start first bit", int'({val_a, ser_a}), 'b10);
      tick();
    end
    cmp("held start single done", cnt, 0);
    start = 1'b0;
    cnt = 0;
    while ((busy_a || busy_b) && cnt < FA + 10) begin
      tick();
      cnt++;
    end
    cmp("idle after held frame", int'(busy_a || busy_b), 0);
    repeat (3) tick();

    // abort during byte 7
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7 * PA + 10) tick();
    cmp("pre-abort busy", int'(busy_a), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cmp("abort outputs", int'({addr_a, ser_a, val_a, busy_a, done_a}), 0);
    cnt = 0;
    repeat (600) begin
      tick();
      if (done_a) cnt++;
    end
    cmp("no done after abort", cnt, 0);
    run_frame("after abort");
    repeat (3) tick();

    // reset mid-shift of byte 3
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3 * PA + 10) tick();
    cmp("pre-reset valid", int'(val_a), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("mid-frame reset outputs", int'({addr_a, ser_a, val_a, busy_a, done_a}), 0);
    run_frame("after reset");
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
